// File: rtl/pe_vector_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : pe_vector_loader
// Description : Upstream feeder for the PE dot-product stage. Packs a serial
//               stream of (x, k) element pairs into two C-lane vectors, owns
//               the PE enable while the PE works on them, captures the PE
//               result and offers it downstream over a valid/ready handshake.
//
// Ports       : clk, rst_n           clock, asynchronous active-low reset
//               s_valid/s_ready      element input handshake
//               s_x, s_k, s_last     element pair and end-of-vector marker
//               pe_enable            PE enable (high only while RUN)
//               pe_x, pe_k           packed vectors, lane i = element i
//               pe_valid, pe_y       PE result valid and result value
//               m_valid/m_ready      result output handshake
//               m_y, m_count, m_err  result, element count, watchdog abort
//
// Options     : define PE_LOADER_WATCHDOG_EN to add a RUN-cycle watchdog that
//               aborts after TIMEOUT cycles without pe_valid (m_err = 1).
//               Without it, RUN waits indefinitely and m_err is tied low.
//
// Revision    : 1.0 - initial release
// ============================================================================
module pe_vector_loader #(
    parameter int C       = 8,
    parameter int W_X     = 8,
    parameter int W_K     = 8,
    parameter int TIMEOUT = 64
) (
    input  logic                     clk,
    input  logic                     rst_n,
    // element input stream
    input  logic                     s_valid,
    output logic                     s_ready,
    input  logic [W_X-1:0]           s_x,
    input  logic [W_K-1:0]           s_k,
    input  logic                     s_last,
    // processing element side
    output logic                     pe_enable,
    output logic [C*W_X-1:0]         pe_x,
    output logic [C*W_K-1:0]         pe_k,
    input  logic                     pe_valid,
    input  logic [W_X-1:0]           pe_y,
    // result output stream
    output logic                     m_valid,
    input  logic                     m_ready,
    output logic [W_X-1:0]           m_y,
    output logic [$clog2(C+1)-1:0]   m_count,
    output logic                     m_err
);

    localparam int IDX_W = $clog2(C);
    localparam int CNT_W = $clog2(C+1);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(C - 1);

    // Elaboration-time sanity check on the configuration.
    generate
        if (C < 2 || TIMEOUT < 1) begin : g_param_check
            $error("pe_vector_loader: C must be >= 2 and TIMEOUT >= 1");
        end
    endgenerate

    typedef enum logic [1:0] {
        ST_FILL = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2
    } state_t;

    // ------------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------------
    state_t             state_q,  state_d;
    logic [IDX_W-1:0]   idx_q,    idx_d;
    logic [W_X-1:0]     lane_x_q [C];
    logic [W_X-1:0]     lane_x_d [C];
    logic [W_K-1:0]     lane_k_q [C];
    logic [W_K-1:0]     lane_k_d [C];
    logic [W_X-1:0]     m_y_q,     m_y_d;
    logic [CNT_W-1:0]   m_count_q, m_count_d;

`ifdef PE_LOADER_WATCHDOG_EN
    // The counter only has to reach TIMEOUT-1: the abort fires on the edge
    // that would have taken it to TIMEOUT.
    localparam int RC_W = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [RC_W-1:0] RC_LAST = RC_W'(TIMEOUT - 1);

    logic [RC_W-1:0]    run_cnt_q, run_cnt_d;
    logic               err_q,     err_d;
`endif

    // Handshake / enable outputs are pure decodes of the registered state, so
    // they all move on the same edge as the state and drop asynchronously
    // with reset.
    assign s_ready   = (state_q == ST_FILL);
    assign pe_enable = (state_q == ST_RUN);
    assign m_valid   = (state_q == ST_HOLD);
    assign m_y       = m_y_q;
    assign m_count   = m_count_q;

`ifdef PE_LOADER_WATCHDOG_EN
    assign m_err     = err_q;
`else
    assign m_err     = 1'b0;
`endif

    // Flatten the lane registers into the packed vectors the PE consumes.
    generate
        for (genvar i = 0; i < C; i++) begin : g_pack
            assign pe_x[i*W_X +: W_X] = lane_x_q[i];
            assign pe_k[i*W_K +: W_K] = lane_k_q[i];
        end
    endgenerate

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        lane_x_d  = lane_x_q;
        lane_k_d  = lane_k_q;
        m_y_d     = m_y_q;
        m_count_d = m_count_q;
`ifdef PE_LOADER_WATCHDOG_EN
        run_cnt_d = run_cnt_q;
        err_d     = err_q;
`endif

        case (state_q)
            ST_FILL: begin
`ifdef PE_LOADER_WATCHDOG_EN
                // Every RUN phase starts counting from zero.
                run_cnt_d = '0;
`endif
                if (s_valid) begin
                    lane_x_d[idx_q] = s_x;
                    lane_k_d[idx_q] = s_k;
                    idx_d           = idx_q + IDX_W'(1);
                    // The last lane ends the vector even without s_last, and
                    // s_last on the last lane is just one ordinary end.
                    if (s_last || (idx_q == LAST_IDX)) begin
                        state_d   = ST_RUN;
                        m_count_d = CNT_W'(idx_q) + CNT_W'(1);
                    end
                end
            end

            ST_RUN: begin
                // A genuine result beats the watchdog on the same edge.
                if (pe_valid) begin
                    m_y_d   = pe_y;
                    state_d = ST_HOLD;
                end
`ifdef PE_LOADER_WATCHDOG_EN
                else if (run_cnt_q == RC_LAST) begin
                    m_y_d   = '0;
                    err_d   = 1'b1;
                    state_d = ST_HOLD;
                end else begin
                    run_cnt_d = run_cnt_q + RC_W'(1);
                end
`endif
            end

            ST_HOLD: begin
                if (m_ready) begin
                    // Clearing the lanes here is what zero-pads the next,
                    // possibly shorter, vector.
                    lane_x_d = '{default: '0};
                    lane_k_d = '{default: '0};
                    idx_d    = '0;
`ifdef PE_LOADER_WATCHDOG_EN
                    err_d    = 1'b0;
`endif
                    state_d  = ST_FILL;
                end
            end

            default: begin
                state_d = ST_FILL;
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ST_FILL;
            idx_q     <= '0;
            lane_x_q  <= '{default: '0};
            lane_k_q  <= '{default: '0};
            m_y_q     <= '0;
            m_count_q <= '0;
`ifdef PE_LOADER_WATCHDOG_EN
            run_cnt_q <= '0;
            err_q     <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            lane_x_q  <= lane_x_d;
            lane_k_q  <= lane_k_d;
            m_y_q     <= m_y_d;
            m_count_q <= m_count_d;
`ifdef PE_LOADER_WATCHDOG_EN
            run_cnt_q <= run_cnt_d;
            err_q     <= err_d;
`endif
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_pe_vector_loader.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module      : tb_pe_vector_loader
// Description : Self-checking bench for pe_vector_loader (C=8, W_X=W_K=8,
//               TIMEOUT=16). Table of directed vectors plus hand-written
//               sequences for reset during RUN and the RUN-stall behaviour
//               (watchdog abort when PE_LOADER_WATCHDOG_EN is defined).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_vector_loader;

    localparam int C       = 8;
    localparam int W_X     = 8;
    localparam int W_K     = 8;
    localparam int TIMEOUT = 16;

    logic                   clk = 1'b0;
    logic                   rst_n = 1'b0;
    logic                   s_valid = 1'b0;
    logic                   s_ready;
    logic [W_X-1:0]         s_x = '0;
    logic [W_K-1:0]         s_k = '0;
    logic                   s_last = 1'b0;
    logic                   pe_enable;
    logic [C*W_X-1:0]       pe_x;
    logic [C*W_K-1:0]       pe_k;
    logic                   pe_valid = 1'b0;
    logic [W_X-1:0]         pe_y = '0;
    logic                   m_valid;
    logic                   m_ready = 1'b0;
    logic [W_X-1:0]         m_y;
    logic [$clog2(C+1)-1:0] m_count;
    logic                   m_err;

    int n_total = 0;
    int n_pass  = 0;

    always #5 clk = ~clk;

    pe_vector_loader #(
        .C(C), .W_X(W_X), .W_K(W_K), .TIMEOUT(TIMEOUT)
    ) dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_x(s_x), .s_k(s_k), .s_last(s_last),
        .pe_enable(pe_enable), .pe_x(pe_x), .pe_k(pe_k),
        .pe_valid(pe_valid), .pe_y(pe_y),
        .m_valid(m_valid), .m_ready(m_ready), .m_y(m_y), .m_count(m_count), .m_err(m_err)
    );

    typedef struct {
        int          n_beats;
        int          gap;            // idle cycles inserted between beats
        bit          last_on_final;  // assert s_last on the final beat
        logic [63:0] src_x;          // beat i = byte i; unused bytes are junk
        logic [63:0] src_k;
        int          latency;        // PE cycles from enable to pe_valid
        logic [7:0]  y;
        int          hold_cycles;    // cycles of m_ready=0 backpressure
        logic [63:0] exp_x;
        logic [63:0] exp_k;
        logic [3:0]  exp_cnt;
    } vec_t;

    vec_t vecs[5];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Sends beats, optionally with s_valid gaps carrying junk that must be ignored.
    task automatic send_beats(input vec_t v);
        for (int b = 0; b < v.n_beats; b++) begin
            if (b > 0) begin
                for (int g = 0; g < v.gap; g++) begin
                    s_valid = 1'b0; s_x = 8'hAA; s_k = 8'h55; s_last = 1'b1;
                    tick();
                end
            end
            chk("s_ready_before_beat", s_ready, 1);
            s_valid = 1'b1;
            s_x     = v.src_x[b*8 +: 8];
            s_k     = v.src_k[b*8 +: 8];
            s_last  = (b == v.n_beats - 1) && v.last_on_final;
            tick();
        end
        s_valid = 1'b0; s_last = 1'b0; s_x = 8'h99; s_k = 8'h66;
    endtask

    task automatic apply_vec(input vec_t v);
        send_beats(v);
        // Final beat edge T: RUN with complete vectors.
        chk("run_entry_sready_low", s_ready, 0);
        chk("run_entry_enable",     pe_enable, 1);
        chk("run_entry_pe_x",       pe_x, v.exp_x);
        chk("run_entry_pe_k",       pe_k, v.exp_k);
        for (int i = 0; i < v.latency - 1; i++) tick();
        chk("run_pre_valid_state", {pe_enable, m_valid}, 2'b10);
        pe_valid = 1'b1; pe_y = v.y;
        tick();
        pe_valid = 1'b0; pe_y = 8'hC3;
        chk("result_valid_enable", {m_valid, pe_enable, s_ready}, 3'b100);
        chk("result_m_y",          m_y, v.y);
        chk("result_m_count",      m_count, v.exp_cnt);
        chk("result_m_err",        m_err, 0);
        chk("result_vectors_held", {pe_x, pe_k}, {v.exp_x, v.exp_k});
        // Backpressure, with a stray pe_valid that HOLD must ignore.
        m_ready = 1'b0;
        for (int i = 0; i < v.hold_cycles; i++) begin
            pe_valid = 1'b1; pe_y = 8'h3C;
            tick();
            chk("hold_stable", {m_valid, s_ready, pe_enable, m_y, m_count},
                {1'b1, 1'b0, 1'b0, v.y, v.exp_cnt});
        end
        pe_valid = 1'b0;
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("handshake_ready",  {s_ready, m_valid, pe_enable}, 3'b100);
        chk("handshake_clears", {pe_x, pe_k}, 128'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{n_beats:8, gap:0, last_on_final:1'b1,
                    src_x:64'h0807060504030201, src_k:64'h0101010101010101,
                    latency:3, y:8'h24, hold_cycles:0,
                    exp_x:64'h0807060504030201, exp_k:64'h0101010101010101, exp_cnt:4'd8};
        vecs[1] = '{n_beats:3, gap:0, last_on_final:1'b1,
                    src_x:64'hFFFFFFFFFF070605, src_k:64'hFFFFFFFFFF020202,
                    latency:2, y:8'h24, hold_cycles:10,
                    exp_x:64'h0000000000070605, exp_k:64'h0000000000020202, exp_cnt:4'd3};
        vecs[2] = '{n_beats:4, gap:2, last_on_final:1'b1,
                    src_x:64'hEEEEEEEE107F80FF, src_k:64'hEEEEEEEE33FE0181,
                    latency:4, y:8'h5A, hold_cycles:2,
                    exp_x:64'h00000000107F80FF, exp_k:64'h0000000033FE0181, exp_cnt:4'd4};
        vecs[3] = '{n_beats:8, gap:0, last_on_final:1'b0,
                    src_x:64'h8877665544332211, src_k:64'hF7F6F5F4F3F2F1F0,
                    latency:1, y:8'h80, hold_cycles:1,
                    exp_x:64'h8877665544332211, exp_k:64'hF7F6F5F4F3F2F1F0, exp_cnt:4'd8};
        vecs[4] = '{n_beats:1, gap:0, last_on_final:1'b1,
                    src_x:64'hDDDDDDDDDDDDDD7F, src_k:64'hDDDDDDDDDDDDDD80,
                    latency:5, y:8'hFF, hold_cycles:0,
                    exp_x:64'h000000000000007F, exp_k:64'h0000000000000080, exp_cnt:4'd1};

        // Reset state
        #12;
        chk("reset_ready_enable", {s_ready, pe_enable, m_valid}, 3'b100);
        chk("reset_vectors",      {pe_x, pe_k}, 128'd0);
        chk("reset_result",       {m_y, m_count, m_err}, 13'd0);
        rst_n = 1'b1;
        tick();

        for (int i = 0; i < 5; i++) apply_vec(vecs[i]);

        // Reset asserted mid-RUN: everything clears without a clock edge.
        send_beats(vecs[1]);
        tick();
        chk("pre_reset_in_run", pe_enable, 1);
        #3;
        rst_n = 1'b0;
        #1;
        chk("async_reset_outputs", {pe_enable, m_valid, s_ready}, 3'b001);
        chk("async_reset_vectors", {pe_x, pe_k}, 128'd0);
        chk("async_reset_count",   m_count, 0);
        #1;
        rst_n = 1'b1;
        tick();
        apply_vec(vecs[0]);

        // PE never answers.
        send_beats(vecs[4]);
`ifdef PE_LOADER_WATCHDOG_EN
        for (int i = 0; i < TIMEOUT - 1; i++) tick();
        chk("wdog_not_yet", {pe_enable, m_valid}, 2'b10);
        tick();
        chk("wdog_abort_state", {m_valid, m_err, pe_enable}, 3'b110);
        chk("wdog_abort_m_y",   m_y, 0);
        chk("wdog_abort_count", m_count, 1);
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("wdog_handshake", {s_ready, m_valid, m_err}, 3'b100);
`else
        for (int i = 0; i < 100; i++) tick();
        chk("stall_still_run", {pe_enable, m_valid, m_err}, 3'b100);
        pe_valid = 1'b1; pe_y = 8'h11;
        tick();
        pe_valid = 1'b0;
        chk("stall_late_result", {m_valid, m_y}, {1'b1, 8'h11});
        m_ready = 1'b1;
        tick();
        m_ready = 1'b0;
        chk("stall_handshake", {s_ready, m_valid}, 2'b10);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/pe_vector_loader.md
# pe_vector_loader

Upstream feeder for the processing element (PE) dot-product stage. It accepts a serial stream of (x, k) element pairs over a valid/ready handshake and packs up to C pairs into the two C-lane vectors the PE consumes. It then drives the PE `enable` until the PE reports `v_valid`, captures the truncated result, and offers it downstream over a second valid/ready handshake. The block owns the PE's enable. Because a low enable clears the PE's counter and accumulator, every vector starts from a clean PE.

## Interface
Parameters:
- `C`, 8, vector length (lanes per PE operation); must be ≥2.
- `W_X`, 8, width of x elements and of the PE result.
- `W_K`, 8, width of k elements.
- `TIMEOUT`, 64, maximum RUN cycles before abort. Used only with the watchdog macro.

Ports:
- `clk`  in  1  clock; all state changes on its rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `s_valid`  in  1  input element pair valid.
- `s_ready`  out  1  loader can accept an element.
- `s_x`  in  W_X  signed x element.
- `s_k`  in  W_K  signed k element.
- `s_last`  in  1  marks this element as the final one of the vector.
- `pe_enable`  out  1  PE enable; high only in RUN.
- `pe_x`  out  C×W_X  packed x vector; lane i is element i.
- `pe_k`  out  C×W_K  packed k vector.
- `pe_valid`  in  1  PE `v_valid`.
- `pe_y`  in  W_X  PE `y_out`.
- `m_valid`  out  1  result valid.
- `m_ready`  in  1  downstream accepts the result.
- `m_y`  out  W_X  captured PE result.
- `m_count`  out  $clog2(C+1)  number of elements loaded, in the range 1..C.
- `m_err`  out  1  result was produced by a watchdog abort.

## Operation
- There are three states: FILL, RUN and HOLD. Reset state is FILL.
- `s_ready` = (state == FILL). It is combinational from state.
- FILL:
  - Each accepted beat (`s_valid` && `s_ready`) writes `s_x` and `s_k` into lane `idx`, then increments `idx`.
  - If `s_last` is high, or `idx` == C-1, the block moves to RUN.
  - Lanes that were never written remain zero. A short vector is therefore zero-padded and the padding adds nothing to the sum.
  - `m_count` latches `idx`+1 on the final beat.
  - A `s_last` arriving together with `idx` == C-1 is a single, normal end of vector.
  - Beats beyond C are impossible because `s_ready` drops.
- RUN:
  - `pe_enable` = 1.
  - `pe_x` and `pe_k` are held constant.
  - On the first edge where `pe_valid` is sampled high: `m_y` <= `pe_y`, `m_valid` <= 1, `pe_enable` <= 0, and the state moves to HOLD.
- HOLD:
  - `m_valid`, `m_y` and `m_count` are held stable until `m_ready` is high.
  - On the handshake edge: `m_valid` <= 0, all lanes are zeroed, `idx` <= 0, `m_err` <= 0, and the state returns to FILL.
- `pe_valid` is ignored in FILL and HOLD. `m_ready` is ignored outside HOLD. Input gaps (`s_valid` low) stall FILL indefinitely.
- There is no arithmetic in this block. Lanes are stored sign-preserving at their native widths. `m_y` is `pe_y` bit-for-bit.

## Timing
- Reset values:
  - State FILL, `s_ready` 1, `pe_enable` 0.
  - `pe_x` and `pe_k` all zero.
  - `m_valid` 0, `m_y` 0, `m_count` 0, `m_err` 0, `idx` 0.
- Final beat accepted at edge T: `pe_enable` = 1 and `s_ready` = 0 from T. The vectors are complete and stable from T.
- `pe_valid` sampled high at edge U (U > T): `m_valid` = 1 and `pe_enable` = 0 from U.
- Handshake at edge V: `s_ready` = 1 from V. The next beat can be accepted at V+1. There is no bubble beyond the handshake cycle.
- Minimum throughput per vector = beats + PE latency + 1 cycle.
- Reset asserted mid-operation: all registers clear immediately without a clock. `pe_enable` drops asynchronously, a partial vector is discarded, and a pending result is lost.

## Configuration
- `PE_LOADER_WATCHDOG_EN`
  - Defined: a RUN cycle counter runs. If `pe_valid` has not been seen after `TIMEOUT` cycles in RUN, the block enters HOLD with `m_y` = 0, `m_err` = 1 and `pe_enable` = 0. `pe_valid` arriving on the timeout edge itself wins and gives a normal result.
  - Not defined: no counter exists, RUN waits forever, and `m_err` is tied 0.

## Test plan
- Full vector: C=8, x=1..8, k=1, `s_last` on beat 8, bench PE model asserts `pe_valid` 3 cycles after enable with `pe_y`=8'h24 -> `pe_x` lanes 1..8, `m_y`=8'h24, `m_count`=8, `m_valid` 1 cycle-exact.
- Short vector: 3 beats x=5,6,7, k=2, `s_last` on beat 3 -> lanes 3..7 zero, `m_count`=3, `s_ready` low from beat-3 edge.
- Backpressure: hold `m_ready`=0 for 10 cycles -> `m_y` and `m_count` stable, `s_ready`=0 throughout; `m_ready`=1 -> `s_ready`=1 the next cycle, lanes cleared.
- Input gaps: `s_valid` toggling 1,0,0,1… -> only handshaked beats stored, indices contiguous.
- Reset mid-RUN: `rst_n` low while `pe_enable`=1 -> `pe_enable`, `m_valid` and lanes 0 immediately; a fresh vector then completes correctly.
- Watchdog (macro defined, TIMEOUT=16): PE never asserts `pe_valid` -> `m_valid`=1, `m_err`=1, `m_y`=0 after 16 RUN cycles. Without the macro: still in RUN at cycle 100.
